// File: rtl/cues_lopen_sched.sv
// Round-robin LOPEN scheduler: opens one self-timed C-element stage at a time, closes it after drain.
// Define CUES_LOPEN_SCHED_TIMEOUT_EN to bound the drain wait and flag TIMEOUT_ERR.
module cues_lopen_sched #(
  parameter int N_STAGE     = 4,
  parameter int DWELL_W     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [N_STAGE-1:0]         REQ,
  input  logic [DWELL_W-1:0]         DWELL,
  input  logic [N_STAGE-1:0]         SENDOUT_A,
  input  logic [N_STAGE-1:0]         ACKOUT_A,
  output logic [N_STAGE-1:0]         LOPEN,
  output logic [$clog2(N_STAGE)-1:0] GNT_ID,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       TIMEOUT_ERR
);
  localparam int ID_W  = $clog2(N_STAGE);
  localparam int BLK_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, OPEN, HOLD, CLOSE} state_t;

  function automatic logic [DWELL_W-1:0] sat_dwell(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  // Lowest offset from ptr+1 wins, so the loop runs from the far end down.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_STAGE-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    pick = ptr;
    for (int i = N_STAGE; i >= 1; i--) begin
      idx = ID_W'((int'(ptr) + i) % N_STAGE);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  logic [N_STAGE-1:0] snd_p [SYNC_STAGES];
  logic [N_STAGE-1:0] ack_p [SYNC_STAGES];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        snd_p[k] <= '0;
        ack_p[k] <= '0;
      end
    end else begin
      snd_p[0] <= SENDOUT_A;
      ack_p[0] <= ACKOUT_A;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        snd_p[k] <= snd_p[k-1];
        ack_p[k] <= ack_p[k-1];
      end
    end
  end

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    pick;
  logic [DWELL_W-1:0] cnt;
  logic [BLK_W-1:0]   blk;
  logic               qseen;
  logic [N_STAGE-1:0] quiet;
  logic               req_sel;
  logic               quiet_sel;
  logic               drain_ok;
  logic               to_hit;
  logic               enter_close;

  // --- synchronized handshake view ---
  assign quiet       = ~(snd_p[SYNC_STAGES-1] ^ ack_p[SYNC_STAGES-1]);
  assign pick        = rr_pick(REQ, rr_ptr);
  assign req_sel     = REQ[GNT_ID];
  assign quiet_sel   = quiet[GNT_ID];
  assign drain_ok    = (blk == '0) && quiet_sel && qseen;
  assign enter_close = !req_sel && (((state == OPEN) && (cnt == DWELL_W'(1))) || (state == HOLD));

`ifdef CUES_LOPEN_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_err;

  assign to_hit      = (to_cnt == TO_W'(TIMEOUT - 1));
  assign TIMEOUT_ERR = to_err;

  always_ff @(posedge CLK) begin
    if (state != CLOSE) to_cnt <= '0;
    else                to_cnt <= to_cnt + TO_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET)                                         to_err <= 1'b0;
    else if ((state == CLOSE) && to_hit && !drain_ok)  to_err <= 1'b1;
  end
`else
  // Keeps the timeout parameter referenced when the timeout logic is compiled out.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign to_hit         = 1'b0;
  assign TIMEOUT_ERR    = 1'b0;
`endif

  // --- scheduler FSM ---
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      LOPEN  <= '0;
      GNT_ID <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      rr_ptr <= ID_W'(N_STAGE - 1);
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (|REQ) begin
            LOPEN  <= N_STAGE'(1) << pick;
            GNT_ID <= pick;
            cnt    <= sat_dwell(DWELL);
            BUSY   <= 1'b1;
            state  <= OPEN;
          end
        end
        OPEN: begin
          if (cnt != DWELL_W'(1)) cnt <= cnt - DWELL_W'(1);
          else if (req_sel)       state <= HOLD;
        end
        HOLD: begin
        end
        CLOSE: begin
          // The first SYNC_STAGES cycles are blanked so stale synchronizer contents cannot
          // count as drained; then quiet must be seen on two consecutive cycles.
          if (drain_ok || to_hit) begin
            DONE   <= 1'b1;
            BUSY   <= 1'b0;
            rr_ptr <= GNT_ID;
            state  <= IDLE;
          end else if (blk != '0) begin
            blk <= blk - BLK_W'(1);
          end else begin
            qseen <= quiet_sel;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_close) begin
        LOPEN <= '0;
        blk   <= BLK_W'(SYNC_STAGES);
        qseen <= 1'b0;
        state <= CLOSE;
      end
    end
  end

endmodule

// File: tb/tb_cues_lopen_sched.sv
// Directed self-checking bench for cues_lopen_sched (N_STAGE=4, SYNC_STAGES=2, TIMEOUT=16).
module tb_cues_lopen_sched;
  localparam int SYNC = 2;
  localparam int TO   = 16;
`ifdef CUES_LOPEN_SCHED_TIMEOUT_EN
  localparam int T4_WAIT = 10;
`else
  localparam int T4_WAIT = 20;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] dwell = 8'd3;
  logic [3:0] snd = '0;
  logic [3:0] ack = '0;
  logic [3:0] lopen;
  logic [1:0] gnt_id;
  logic       busy;
  logic       done;
  logic       to_err;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_seq [6] = '{0, 1, 3, 0, 1, 3};

  always #5 clk = ~clk;

  cues_lopen_sched #(
    .N_STAGE(4), .DWELL_W(8), .SYNC_STAGES(SYNC), .TIMEOUT(TO)
  ) dut (
    .CLK(clk), .RESET(rst), .REQ(req), .DWELL(dwell),
    .SENDOUT_A(snd), .ACKOUT_A(ack),
    .LOPEN(lopen), .GNT_ID(gnt_id), .BUSY(busy), .DONE(done), .TIMEOUT_ERR(to_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    snd = '0;
    ack = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_lopen(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (lopen == '0 && n < 50);
    chk(tag, 32'(lopen != '0), 32'd1);
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 200);
    chk(tag, 32'(done), 32'd1);
  endtask

  always @(negedge clk) chk("onehot0", 32'($onehot0(lopen)), 32'd1);

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // T1: reset values, first grant, dwell length, drain latency, next grant
    do_reset();
    chk("rst_lopen", 32'(lopen), 32'd0);
    chk("rst_gnt", 32'(gnt_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_toerr", 32'(to_err), 32'd0);
    req = 4'b1111;
    dwell = 8'd3;
    tick();
    chk("t1_lopen0", 32'(lopen), 32'b0001);
    chk("t1_gnt0", 32'(gnt_id), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    req = 4'b1110;
    repeat (2) begin
      tick();
      chk("t1_open", 32'(lopen), 32'b0001);
    end
    tick();
    chk("t1_closed", 32'(lopen), 32'd0);
    wait_done("t1_done", n);
    chk("t1_done_lat", 32'(n), 32'(SYNC + 2));
    chk("t1_busy_idle", 32'(busy), 32'd0);
    chk("t1_gnt_kept", 32'(gnt_id), 32'd0);
    tick();
    chk("t1_next", 32'(lopen), 32'b0010);
    chk("t1_gnt1", 32'(gnt_id), 32'd1);
    req = '0;

    // T2: round-robin order with stages 0,1,3 re-requesting after each grant
    do_reset();
    req = 4'b1011;
    dwell = 8'd1;
    for (int g = 0; g < 6; g++) begin
      wait_lopen("t2_grant", n);
      chk("t2_gap", 32'(n), 32'd1);
      chk("t2_gnt", 32'(gnt_id), 32'(exp_seq[g]));
      chk("t2_lopen", 32'(lopen), 32'd1 << exp_seq[g]);
      req = 4'b1011 & ~(4'b0001 << exp_seq[g]);
      wait_done("t2_done", n);
      chk("t2_done_lat", 32'(n), 32'(SYNC + 3));
      req = 4'b1011;
    end
    req = '0;

    // T3: hold extends the grant past the dwell
    do_reset();
    req = 4'b0100;
    dwell = 8'd2;
    tick();
    chk("t3_open", 32'(lopen), 32'b0100);
    repeat (9) begin
      tick();
      chk("t3_hold", 32'(lopen), 32'b0100);
    end
    req = '0;
    tick();
    chk("t3_closed", 32'(lopen), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    wait_done("t3_done", n);
    chk("t3_done_lat", 32'(n), 32'(SYNC + 2));

    // T4: close waits for the stage handshake to settle
    do_reset();
    snd = 4'b0010;
    req = 4'b0010;
    dwell = 8'd2;
    tick();
    chk("t4_open", 32'(lopen), 32'b0010);
    req = '0;
    tick();
    tick();
    chk("t4_closed", 32'(lopen), 32'd0);
    repeat (T4_WAIT) begin
      tick();
      chk("t4_busy", 32'(busy), 32'd1);
      chk("t4_nodone", 32'(done), 32'd0);
    end
    ack = 4'b0010;
    wait_done("t4_done", n);
    chk("t4_done_lat", 32'(n), 32'(SYNC + 2));
    chk("t4_toerr", 32'(to_err), 32'd0);
    snd = '0;
    ack = '0;

    // T6: reset during hold; rr pointer returns to favour stage 0
    req = 4'b0100;
    dwell = 8'd1;
    tick();
    chk("t6_open", 32'(lopen), 32'b0100);
    chk("t6_gnt", 32'(gnt_id), 32'd2);
    tick();
    tick();
    chk("t6_hold", 32'(lopen), 32'b0100);
    chk("t6_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_rst_lopen", 32'(lopen), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_gnt", 32'(gnt_id), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    req = 4'b1111;
    tick();
    chk("t6_regrant", 32'(lopen), 32'b0001);
    chk("t6_regrant_id", 32'(gnt_id), 32'd0);
    req = '0;
    wait_done("t6_done", n);

    // T7: DWELL=0 behaves as a one-cycle dwell
    req = 4'b1000;
    dwell = 8'd0;
    tick();
    chk("t7_open", 32'(lopen), 32'b1000);
    req = '0;
    tick();
    chk("t7_one_cycle", 32'(lopen), 32'd0);
    wait_done("t7_done", n);
    chk("t7_done_lat", 32'(n), 32'(SYNC + 2));

`ifdef CUES_LOPEN_SCHED_TIMEOUT_EN
    // T5: drain never completes, timeout releases the scheduler
    snd = 4'b0001;
    req = 4'b0001;
    dwell = 8'd1;
    tick();
    chk("t5_open", 32'(lopen), 32'b0001);
    req = '0;
    tick();
    chk("t5_closed", 32'(lopen), 32'd0);
    wait_done("t5_done", n);
    chk("t5_done_lat", 32'(n), 32'(TO));
    chk("t5_err", 32'(to_err), 32'd1);
    snd = '0;
    req = 4'b0010;
    tick();
    chk("t5_next", 32'(lopen), 32'b0010);
    chk("t5_err_hold", 32'(to_err), 32'd1);
    req = '0;
    wait_done("t5_next_done", n);
    chk("t5_next_lat", 32'(n), 32'(SYNC + 3));
    chk("t5_err_sticky", 32'(to_err), 32'd1);
`else
    chk("t5_toerr_tied", 32'(to_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
